sa_host_ctrl: RTL and testbench

SA_HOST_CTRL -- requirements
Module: sa_host_ctrl

---
 rtl/sa_pkg.sv | 18 +
 rtl/sa_host_buf.sv | 31 +++
 rtl/sa_host_ctrl.sv | 164 ++++++++++++++++
 tb/tb_sa_host_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared constants and FSM encoding for the systolic-array host controller.
package sa_pkg;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int BEATS = 16;
    localparam int TMO   = 256;

    typedef enum logic [2:0] {
        IDLE,
        ARST,
        LOAD,
        WAIT,
        COLLECT,
        DONE
    } state_t;

endpackage

// File: rtl/sa_host_buf.sv
// 16-entry register file with one write port, one registered read port
// and asynchronous clear of both the storage and the read register.
module sa_host_buf #(
    parameter int DW = 8
) (
    input  logic          clk_p,
    input  logic          rstn_p,
    input  logic          we,
    input  logic [3:0]    waddr,
    input  logic [DW-1:0] wdata,
    input  logic [3:0]    raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [16];

    always_ff @(posedge clk_p or negedge rstn_p) begin
        if (!rstn_p) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sa_host_ctrl.sv
// Host-side sequencer for a 4x4 systolic array: resets it, streams A/B operands,
// collects the 16 results. Optional completion timeout: SA_HOST_TIMEOUT_EN.
module sa_host_ctrl #(
    parameter int N   = sa_pkg::N,
    parameter int DW  = sa_pkg::DW,
    parameter int TMO = sa_pkg::TMO
) (
    input  logic          clk_p,
    input  logic          rstn_p,
    input  logic          start,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [3:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [3:0]    rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          sa_rstn,
    output logic          sa_en,
    output logic [DW-1:0] sa_shift_in_A,
    output logic [DW-1:0] sa_shift_in_B,
    input  logic [DW-1:0] sa_shift_out,
    input  logic          sa_ack
);
    import sa_pkg::*;

    localparam logic [3:0] LAST = 4'(BEATS - 1);

    if (N * N != BEATS || TMO < 2) begin : g_cfg_check
        $error("sa_host_ctrl: unsupported N/TMO configuration");
    end

    state_t        state;
    logic [3:0]    k;
    logic [3:0]    idx;
    logic          arst_q;
    logic          pres_q;
    logic          a_we, b_we, c_we;
    logic [3:0]    a_raddr, b_raddr;
    logic [DW-1:0] a_rdata, b_rdata;

    assign a_we = wr_en & ~wr_sel & ~busy;
    assign b_we = wr_en &  wr_sel & ~busy;
    assign c_we = sa_ack & ((state == WAIT) | (state == COLLECT));

    // With i=k[3:2], j=k[1:0]: A[i*4+3-j] and B[(3-j)*4+i]; 3-j is ~j in 2 bits.
    assign a_raddr = {k[3:2], ~k[1:0]};
    assign b_raddr = {~k[1:0], k[3:2]};

    // Registered read makes beat k appear one cycle after it is addressed.
    assign sa_shift_in_A = pres_q ? a_rdata : '0;
    assign sa_shift_in_B = pres_q ? b_rdata : '0;
    assign sa_rstn       = rstn_p & ~arst_q;

    sa_host_buf #(.DW(DW)) u_a_buf (
        .clk_p(clk_p), .rstn_p(rstn_p), .we(a_we), .waddr(wr_addr),
        .wdata(wr_data), .raddr(a_raddr), .rdata(a_rdata)
    );

    sa_host_buf #(.DW(DW)) u_b_buf (
        .clk_p(clk_p), .rstn_p(rstn_p), .we(b_we), .waddr(wr_addr),
        .wdata(wr_data), .raddr(b_raddr), .rdata(b_rdata)
    );

    sa_host_buf #(.DW(DW)) u_c_buf (
        .clk_p(clk_p), .rstn_p(rstn_p), .we(c_we), .waddr(idx),
        .wdata(sa_shift_out), .raddr(rd_addr), .rdata(rd_data)
    );

`ifdef SA_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TMO + 1);
    logic [TW-1:0] tmo_cnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk_p or negedge rstn_p) begin
        if (!rstn_p) begin
            state   <= IDLE;
            k       <= '0;
            idx     <= '0;
            arst_q  <= 1'b0;
            pres_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sa_en   <= 1'b0;
`ifdef SA_HOST_TIMEOUT_EN
            err     <= 1'b0;
            tmo_cnt <= '0;
`endif
        end else begin
            done   <= 1'b0;
            pres_q <= (state == LOAD);
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= ARST;
                        busy   <= 1'b1;
                        arst_q <= 1'b1;
                        k      <= '0;
`ifdef SA_HOST_TIMEOUT_EN
                        err    <= 1'b0;
`endif
                    end
                end
                ARST: begin
                    if (k == 4'd1) begin
                        state  <= LOAD;
                        arst_q <= 1'b0;
                        sa_en  <= 1'b1;
                        k      <= '0;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                LOAD: begin
                    k <= k + 1'b1;
                    if (k == LAST) begin
                        state   <= WAIT;
                        sa_en   <= 1'b0;
                        idx     <= '0;
`ifdef SA_HOST_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (sa_ack) begin
                        state <= COLLECT;
                        idx   <= 4'd1;
                    end
                end
                COLLECT: begin
                    if (sa_ack) begin
                        idx <= idx + 1'b1;
                        if (idx == LAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
`ifdef SA_HOST_TIMEOUT_EN
            // Expiry overrides whatever the collection logic decided this cycle.
            if (state == WAIT || state == COLLECT) begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (tmo_cnt == TW'(TMO - 1)) begin
                    state <= DONE;
                    done  <= 1'b1;
                    err   <= 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_sa_host_ctrl.sv
// Directed self-checking bench for sa_host_ctrl with stream/result scoreboards.
module tb_sa_host_ctrl;

    localparam int DW = 8;

    logic          clk_p = 1'b0;
    logic          rstn_p = 1'b0;
    logic          start = 1'b0;
    logic          wr_en = 1'b0;
    logic          wr_sel = 1'b0;
    logic [3:0]    wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [3:0]    rd_addr = '0;
    logic [DW-1:0] sa_shift_out = '0;
    logic          sa_ack = 1'b0;
    logic [DW-1:0] rd_data, sa_shift_in_A, sa_shift_in_B;
    logic          busy, done, err, sa_rstn, sa_en;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] a_m [16];
    logic [DW-1:0] b_m [16];
    logic [DW-1:0] res_m [16];
    logic [DW-1:0] qa [$];
    logic [DW-1:0] qb [$];
    logic [DW-1:0] qc [$];

    sa_host_ctrl #(.N(4), .DW(DW), .TMO(256)) dut (
        .clk_p(clk_p), .rstn_p(rstn_p), .start(start),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err),
        .sa_rstn(sa_rstn), .sa_en(sa_en),
        .sa_shift_in_A(sa_shift_in_A), .sa_shift_in_B(sa_shift_in_B),
        .sa_shift_out(sa_shift_out), .sa_ack(sa_ack)
    );

    always #5 clk_p = ~clk_p;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic writeOperand(input bit sel, input int addr, input logic [DW-1:0] data);
        @(posedge clk_p); #1;
        wr_en = 1'b1; wr_sel = sel; wr_addr = 4'(addr); wr_data = data;
        @(posedge clk_p); #1;
        wr_en = 1'b0;
        if (sel) b_m[addr] = data;
        else     a_m[addr] = data;
    endtask

    task automatic readResults(input string tag);
        logic [31:0] exp;
        for (int a = 0; a < 16; a++) begin
            @(posedge clk_p); #1;
            rd_addr = 4'(a);
            @(posedge clk_p);
            @(negedge clk_p);
            exp = (qc.size() != 0) ? 32'(qc.pop_front()) : 32'hDEAD_BEEF;
            checkOutput($sformatf("%s_c%0d", tag, a), 32'(rd_data), exp);
        end
    endtask

    // Runs one job: gapped selects the 1,0,1,1,0 ack pattern, inject pokes start/write mid-LOAD.
    task automatic applyStimulus(input bit gapped, input int n_acks, input bit inject);
        int stored = 0, sent = 0, step = 0;
        int done_cnt = 0, done_cyc = 0, last_cyc = 0;
        bit fin = 0;
        bit a;
        logic [DW-1:0] exp_a, exp_b;
        qa.delete(); qb.delete(); qc.delete();
        for (int kk = 0; kk < 16; kk++) begin
            qa.push_back(a_m[(kk / 4) * 4 + 3 - (kk % 4)]);
            qb.push_back(b_m[(3 - (kk % 4)) * 4 + (kk / 4)]);
        end
        @(posedge clk_p); #1;
        start = 1'b1;
        for (int cyc = 1; cyc <= 150 && !fin; cyc++) begin
            @(posedge clk_p); #1;
            start = 1'b0;
            wr_en = 1'b0;
            if (inject && cyc == 10) begin
                start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd15; wr_data = 8'hFF;
            end
            sa_ack = 1'b0;
            sa_shift_out = 8'hEE;
            if (cyc >= 19 && sent < n_acks) begin
                a = (stored >= 16) || !gapped || ((step % 5) != 1 && (step % 5) != 4);
                step++;
                if (a) begin
                    sa_ack = 1'b1;
                    if (stored < 16) begin
                        sa_shift_out = res_m[stored];
                        qc.push_back(res_m[stored]);
                        stored++;
                        if (stored == 16) last_cyc = cyc;
                    end else begin
                        sa_shift_out = 8'(200 + sent);
                    end
                    sent++;
                end
            end
            @(negedge clk_p);
            if (cyc <= 20) begin
                checkOutput($sformatf("sa_rstn_c%0d", cyc), 32'(sa_rstn), 32'(cyc > 2));
                checkOutput($sformatf("sa_en_c%0d", cyc), 32'(sa_en), 32'(cyc >= 3 && cyc <= 18));
                checkOutput($sformatf("busy_c%0d", cyc), 32'(busy), 32'd1);
                if (cyc >= 4 && cyc <= 19) begin
                    exp_a = (qa.size() != 0) ? qa.pop_front() : 8'h5A;
                    exp_b = (qb.size() != 0) ? qb.pop_front() : 8'h5A;
                end else begin
                    exp_a = '0;
                    exp_b = '0;
                end
                checkOutput($sformatf("streamA_c%0d", cyc), 32'(sa_shift_in_A), 32'(exp_a));
                checkOutput($sformatf("streamB_c%0d", cyc), 32'(sa_shift_in_B), 32'(exp_b));
            end
            if (cyc == 1) checkOutput("err_cleared_on_start", 32'(err), 32'd0);
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (done_cyc != 0 && cyc == done_cyc + 1) begin
                checkOutput("busy_after_done", 32'(busy), 32'd0);
                fin = 1;
            end
        end
        sa_ack = 1'b0;
        checkOutput("done_cycle", 32'(done_cyc), 32'(last_cyc + 1));
        checkOutput("done_pulses", 32'(done_cnt), 32'd1);
        checkOutput("err_after_job", 32'(err), 32'd0);
    endtask

    initial begin
        int s;
        int tmo_cyc;
        int done_seen;
        logic tmo_err;

        $display("[TB] reset checks");
        repeat (3) @(posedge clk_p);
        @(negedge clk_p);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_sa_en", 32'(sa_en), 32'd0);
        checkOutput("rst_sa_rstn", 32'(sa_rstn), 32'd0);
        checkOutput("rst_streamA", 32'(sa_shift_in_A), 32'd0);
        checkOutput("rst_streamB", 32'(sa_shift_in_B), 32'd0);
        checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
        @(posedge clk_p); #1;
        rstn_p = 1'b1;
        @(negedge clk_p);
        checkOutput("idle_sa_rstn", 32'(sa_rstn), 32'd1);

        $display("[TB] job 1: ramp operands, constant results, busy pokes");
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                writeOperand(1'b0, r * 4 + c, 8'(c + 1));
                writeOperand(1'b1, r * 4 + c, 8'(r + 1));
            end
        end
        for (int n = 0; n < 16; n++) res_m[n] = 8'd30;
        applyStimulus(1'b0, 16, 1'b1);
        readResults("job1");

        $display("[TB] job 2: border A, affine B, product results");
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                writeOperand(1'b0, r * 4 + c, (r == 0 || r == 3 || c == 0 || c == 3) ? 8'd1 : 8'd0);
                writeOperand(1'b1, r * 4 + c, 8'(2 * (r * 4 + c) + 12));
            end
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                s = 0;
                for (int t = 0; t < 4; t++) s += int'(a_m[r * 4 + t]) * int'(b_m[t * 4 + c]);
                res_m[r * 4 + c] = 8'(s);
            end
        end
        applyStimulus(1'b0, 16, 1'b0);
        readResults("job2");

        $display("[TB] job 3: gapped acks, 20 beats");
        for (int n = 0; n < 16; n++) res_m[n] = 8'(100 + n);
        applyStimulus(1'b1, 20, 1'b0);
        readResults("job3");

        $display("[TB] job 4: no acknowledge");
        tmo_cyc = 0;
        done_seen = 0;
        tmo_err = 1'b0;
        @(posedge clk_p); #1;
        start = 1'b1;
`ifdef SA_HOST_TIMEOUT_EN
        for (int cyc = 1; cyc <= 400 && tmo_cyc == 0; cyc++) begin
            @(posedge clk_p); #1;
            start = 1'b0;
            @(negedge clk_p);
            if (done === 1'b1) begin
                tmo_cyc = cyc;
                tmo_err = err;
            end
        end
        checkOutput("tmo_done_cycle", 32'(tmo_cyc), 32'd275);
        checkOutput("tmo_err", 32'(tmo_err), 32'd1);
        @(negedge clk_p);
        checkOutput("tmo_busy_after", 32'(busy), 32'd0);
`else
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(posedge clk_p); #1;
            start = 1'b0;
            @(negedge clk_p);
            if (done === 1'b1) done_seen++;
        end
        checkOutput("noack_busy", 32'(busy), 32'd1);
        checkOutput("noack_done", 32'(done_seen), 32'd0);
        checkOutput("noack_err", 32'(err), 32'd0);
        @(posedge clk_p); #1;
        rstn_p = 1'b0;
        @(posedge clk_p); #1;
        rstn_p = 1'b1;
`endif

        $display("[TB] job 5: reset during LOAD");
        @(posedge clk_p); #1;
        start = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clk_p); #1;
            start = 1'b0;
            @(negedge clk_p);
            if (cyc == 1) checkOutput("mid_err_cleared", 32'(err), 32'd0);
            if (cyc == 10) checkOutput("mid_l7_sa_en", 32'(sa_en), 32'd1);
        end
        #1;
        rstn_p = 1'b0;
        #1;
        checkOutput("mid_busy", 32'(busy), 32'd0);
        checkOutput("mid_done", 32'(done), 32'd0);
        checkOutput("mid_err", 32'(err), 32'd0);
        checkOutput("mid_sa_en", 32'(sa_en), 32'd0);
        checkOutput("mid_sa_rstn", 32'(sa_rstn), 32'd0);
        checkOutput("mid_streamA", 32'(sa_shift_in_A), 32'd0);
        checkOutput("mid_streamB", 32'(sa_shift_in_B), 32'd0);
        checkOutput("mid_rd_data", 32'(rd_data), 32'd0);
        repeat (2) @(posedge clk_p);
        #1;
        rstn_p = 1'b1;
        for (int n = 0; n < 16; n++) begin
            a_m[n] = '0;
            b_m[n] = '0;
        end
        @(negedge clk_p);
        checkOutput("post_rst_sa_rstn", 32'(sa_rstn), 32'd1);
        checkOutput("post_rst_busy", 32'(busy), 32'd0);
        qc.delete();
        for (int n = 0; n < 16; n++) qc.push_back('0);
        readResults("cleared");

        for (int c = 0; c < 4; c++) begin
            writeOperand(1'b0, c, 8'(5 + c));
            writeOperand(1'b1, c, 8'(9 + c));
        end
        for (int n = 0; n < 16; n++) res_m[n] = 8'(50 + n);
        applyStimulus(1'b0, 16, 1'b0);
        readResults("job5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
